// File: rtl/flag_unit.sv
// Condition-flag register with masked writes, same-cycle bypass, a single
// checkpoint for flush recovery, and an outstanding flag-setter tracker.
module flag_unit #(
   parameter int unsigned NUM_FLAGS    = 4,
   parameter int unsigned MAX_INFLIGHT = 3
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_FLAGS-1:0]                  flags_in,
   input  logic                                  set_en,
   input  logic [NUM_FLAGS-1:0]                  set_mask,
   input  logic                                  stall,
   input  logic                                  issue_set,
   input  logic                                  ckpt_save,
   input  logic                                  ckpt_restore,
   output logic [NUM_FLAGS-1:0]                  flags_q,
   output logic [NUM_FLAGS-1:0]                  flags_fwd,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
   output logic                                  flags_busy,
   output logic                                  track_err
);

   localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

   logic [NUM_FLAGS-1:0] ckpt_q;
   logic [NUM_FLAGS-1:0] flags_nxt;
   logic [CW-1:0]        inflight_nxt;
   logic                 err_nxt;
   logic                 upd;
   logic                 inc;
   logic                 dec;

   assign upd = set_en & ~stall & ~ckpt_restore;
   assign inc = issue_set & ~stall & ~ckpt_restore;
   assign dec = upd;

   // Masked merge of ALU flags into the architectural value.
   always_comb begin
      flags_nxt = flags_q;
      if (upd) begin
         flags_nxt = (flags_in & set_mask) | (flags_q & ~set_mask);
      end
   end

   // Bypass is suppressed under reset so consumers never see flags_in early.
   always_comb begin
      flags_fwd = flags_q;
      if (!reset) begin
         flags_fwd = flags_nxt;
      end
   end

   // Saturating counter; over/underflow attempts hold the count and flag an error.
   always_comb begin
      inflight_nxt = inflight;
      err_nxt      = track_err;
      if (inc && !dec) begin
         if (inflight == CNT_MAX) begin
            err_nxt = 1'b1;
         end else begin
            inflight_nxt = inflight + CW'(1);
         end
      end else if (dec && !inc) begin
         if (inflight == CW'(0)) begin
            err_nxt = 1'b1;
         end else begin
            inflight_nxt = inflight - CW'(1);
         end
      end
   end

   assign flags_busy = (inflight != CW'(0));

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= '0;
         ckpt_q    <= '0;
         inflight  <= '0;
         track_err <= 1'b0;
      end else if (ckpt_restore) begin
         flags_q  <= ckpt_q;
         inflight <= '0;
      end else begin
         flags_q   <= flags_nxt;
         inflight  <= inflight_nxt;
         track_err <= err_nxt;
         // Checkpoint takes the pre-edge flags, never the value written this cycle.
         if (ckpt_save && !stall) begin
            ckpt_q <= flags_q;
         end
      end
   end

endmodule
